apb_arb_master: RTL

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 29 ++
 rtl/apb_arb_master.sv | 134 +++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  localparam int unsigned AddrWDefault = 8;
  localparam int unsigned DataWDefault = 8;

  // Contention goes to whoever was not served last; a lone request wins outright.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    return (req0 && req1) ? ~last : ~req0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester served.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic update_i,
  input  logic served_i,
  output logic gnt_o
);

  logic last_q;

  // Reset value of 1 means requester 0 is favoured first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (update_i) begin
      last_q <= served_i;
    end
  end

  always_comb begin
    gnt_o = rr_pick(req0_i, req1_i, last_q);
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters with round-robin arbitration.
// Define APB_TIMEOUT_EN to end stalled ACCESS phases with an error after TIMEOUT cycles.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              req0,
  input  logic              req1,
  input  logic              write0,
  input  logic              write1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              psel0,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              gnt;
  logic              timed_out;
  logic              complete;

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk),
    .rst_ni   (preset),
    .req0_i   (req0),
    .req1_i   (req1),
    .update_i (complete),
    .served_i (owner_q),
    .gnt_o    (gnt)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == StAccess && !pready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires on the TIMEOUT-th stalled ACCESS cycle, counting the current one.
  assign timed_out = (state_q == StAccess) && !pready && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  assign complete = (state_q == StAccess) && (pready || timed_out);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StSetup;
          owner_d  = gnt;
          pwrite_d = gnt ? write1 : write0;
          paddr_d  = gnt ? addr1 : addr0;
          pwdata_d = gnt ? wdata1 : wdata0;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: if (complete) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  always_comb begin
    psel0   = (state_q != StIdle);
    penable = (state_q == StAccess);
    pwrite  = pwrite_q;
    paddr   = paddr_q;
    pwdata  = pwdata_q;
    done0   = complete && !owner_q;
    done1   = complete && owner_q;
    // A timeout only occurs with pready low, so read data is zero in that case.
    rdata   = (state_q == StAccess && pready) ? prdata : '0;
    err     = ((state_q == StAccess) && pready && pslverr) || timed_out;
  end

endmodule
